// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the registered round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of an index field for n channels; never narrower than one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotate-priority search: first requester at or after i_ptr, wrapping modulo N_CH.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]              i_req,
    input  logic [clog2_safe(N_CH)-1:0]  i_ptr,
    output logic [clog2_safe(N_CH)-1:0]  o_gnt_idx,
    output logic                         o_gnt_any
);

    localparam int SEL_W = clog2_safe(N_CH);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester to i_ptr is written last.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_idx     = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N_CH;
            if (i_req[w_idx]) begin
                o_gnt_idx = SEL_W'(w_idx);
                o_gnt_any = 1'b1;
            end else begin
                o_gnt_any = o_gnt_any;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux: fixed-select or round-robin grant, one beat per cycle.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mode,
    input  logic [clog2_safe(N_CH)-1:0]  i_sel,
    input  logic [N_CH-1:0]              i_in_valid,
    input  logic [N_CH*WIDTH-1:0]        i_in_data,
    output logic [N_CH-1:0]              o_in_ready,
    output logic                         o_out_valid,
    output logic [WIDTH-1:0]             o_out_data,
    output logic [clog2_safe(N_CH)-1:0]  o_out_ch,
    input  logic                         i_out_ready
);

    localparam int SEL_W = clog2_safe(N_CH);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_any;
    logic             w_load;
    logic [N_CH-1:0]  w_in_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_ptr_nxt;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req     (i_in_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_any (w_arb_any)
    );

    assign w_load = !r_out_valid || i_out_ready;

    // Grant selection and ready fan-out; fixed-mode ready ignores in_valid.
    always_comb begin
        w_gnt      = '0;
        w_gnt_any  = 1'b0;
        w_in_ready = '0;
        case (i_mode)
            MODE_FIXED: begin
                w_gnt     = i_sel;
                w_gnt_any = (int'(i_sel) < N_CH);
            end
            MODE_RR: begin
                w_gnt     = w_arb_idx;
                w_gnt_any = w_arb_any;
            end
            default: begin
                w_gnt     = '0;
                w_gnt_any = 1'b0;
            end
        endcase
        for (int i = 0; i < N_CH; i++) begin
            w_in_ready[i] = w_load && w_gnt_any && (w_gnt == SEL_W'(i));
        end
    end

    assign w_xfer = |(w_in_ready & i_in_valid);

    // Data mux for the granted channel.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_data = i_in_data[i*WIDTH +: WIDTH];
            end else begin
                w_data = w_data;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == SEL_W'(N_CH - 1)) ? '0 : (w_gnt + SEL_W'(1));

    // Output register and rr pointer; a held beat is only replaced when load allows it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_ch    <= w_gnt;
            if (i_mode == MODE_RR) begin
                r_ptr <= w_ptr_nxt;
            end else begin
                r_ptr <= r_ptr;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshakes on every input and on the output. It selects one input per cycle, either by an externally driven select (fixed mode) or by a fair round-robin arbiter (rr mode), and registers the chosen beat together with its channel number. It is the next-generation channel selector for the combinational datapath library, where a plain select-driven mux cannot apply backpressure or share a sink fairly.

## Interface
- N_CH, 4, number of input channels; legal range ≥ 2.
- WIDTH, 8, data width per channel in bits; legal range ≥ 1.
- SEL_W, derived localparam = $clog2(N_CH), width of the select and channel-id fields. Not overridable.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode; ignored in rr mode.
- in_valid  input  N_CH  per-channel valid; bit i belongs to channel i.
- in_data  input  N_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel ready (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  channel index the held beat came from.
- out_ready  input  1  downstream accepts the beat.

## Operation
- load = !out_valid || out_ready. The output register accepts a new beat only when load is 1.
- Fixed mode:
  - grant = sel.
  - in_ready[i] = load && (i == sel), independent of in_valid.
  - A transfer occurs on channel sel when in_valid[sel] && in_ready[sel].
- Round-robin mode:
  - grant = the first i with in_valid[i] = 1, scanning ptr, ptr+1, … mod N_CH.
  - in_ready[grant] = load && |in_valid; every other in_ready bit is 0.
- At most one in_ready bit is high in any cycle.
- On a transfer:
  - out_data ← in_data of the granted channel.
  - out_ch ← grant.
  - out_valid ← 1.
  - In rr mode only, ptr ← (grant + 1) mod N_CH; wraps from N_CH-1 to 0.
- ptr changes only on rr-mode transfers. Fixed-mode transfers and idle cycles leave it unchanged.
- If out_valid && out_ready and no transfer occurs, out_valid ← 0. out_data and out_ch keep their last values.
- Simultaneous drain and load in the same cycle gives a back-to-back beat, so out_valid stays 1.
- Out-of-range sel (≥ N_CH, possible when N_CH is not a power of two): no grant, all in_ready = 0, no transfer.
- A change of mode or sel takes effect on the next load decision. A beat already held in the output register is never altered or dropped.
- No combinational path from in_* to out_*. The only combinational outputs are in_ready, which depends on in_valid, mode, sel, out_valid, out_ready and ptr.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset values (on rst assertion, asynchronously): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
- in_ready is 1 during reset only as the combinational function above allows, since out_valid = 0 forces load = 1. Upstream must not present valid during reset.
- Reset mid-operation discards the held beat and returns ptr to 0.
- The first edge after rst deassertion behaves like any normal cycle.
- out_valid, out_data and out_ch are stable while out_valid && !out_ready.

## Structure
- Shared package stream_mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants.
  - A clog2-safe helper function, if the toolchain needs one.
- Sub-module rr_arbiter (parameter N_CH):
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Purely combinational rotate-priority search.
  - The top level owns ptr, the output register and the handshake logic.

## Test plan
- Fixed mode, N_CH=4, WIDTH=8, sel=2, in_valid=4'b1111, in_data channel 2 = 8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- RR mode, all four valid, constant out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; exactly one in_ready bit high per cycle.
- RR mode, in_valid=4'b1010, ptr=0 -> grant 1, then 3, then 1; ptr after the last grant = 2.
- Backpressure: beat held with out_ready=0 for 3 cycles -> out_data/out_ch unchanged, in_ready=0; out_ready=1 with new valid -> back-to-back beat, out_valid stays 1.
- N_CH=3, fixed mode, sel=3 with in_valid=3'b111 -> in_ready=0, out_valid stays 0.
- Assert rst while out_valid=1 and ptr=2 -> out_valid=0, out_data=0, out_ch=0 immediately; first rr grant after release starts scanning at channel 0.
